// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with valid-qualified input,
// overlap/non-overlap modes, one-cycle registered detect pulse and saturating match counter.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic               seq_in,
    input  logic               enable,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clear,
    output logic               detect_out,
    output logic [CNT_W-1:0]   detect_count,
    output logic               cfg_err,
    output logic               armed
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_detect;
    logic [CNT_W-1:0]   r_count;
    logic               r_cfg_err;

    logic               w_cfg_valid;
    logic               w_shift;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_fill_ok;
    logic               w_match;
    logic [LEN_W-1:0]   w_fill_next;
    logic [CNT_W-1:0]   w_cnt_max;

    assign w_cfg_valid = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
    // A coincident cfg_load discards the input bit.
    assign w_shift     = (r_state == ST_ARMED) && enable && in_valid && !cfg_load;
    assign w_hist_next = (r_hist << 1) | {{(MAX_LEN-1){1'b0}}, seq_in};
    // Fill is saturated at L, so "fill including new bit >= L" is fill >= L-1.
    assign w_fill_ok   = (r_fill >= (r_len - LEN_W'(1)));
    assign w_match     = w_shift && w_fill_ok &&
                         (((w_hist_next ^ r_pattern) & w_mask) == {MAX_LEN{1'b0}});
    assign w_cnt_max   = {CNT_W{1'b1}};

    // Select the low L history bits that take part in the comparison.
    always_comb begin
        w_mask = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < r_len) begin
                w_mask[i] = 1'b1;
            end else begin
                w_mask[i] = 1'b0;
            end
        end
    end

    // Next fill count: restart after a non-overlapping match, else saturate at L.
    always_comb begin
        w_fill_next = r_fill;
        if (w_match && !r_overlap) begin
            w_fill_next = {LEN_W{1'b0}};
        end else if (r_fill < r_len) begin
            w_fill_next = r_fill + LEN_W'(1);
        end else begin
            w_fill_next = r_fill;
        end
    end

    // Control FSM, configuration, history and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_pattern <= {MAX_LEN{1'b0}};
            r_len     <= {LEN_W{1'b0}};
            r_overlap <= 1'b0;
            r_hist    <= {MAX_LEN{1'b0}};
            r_fill    <= {LEN_W{1'b0}};
            r_detect  <= 1'b0;
            r_count   <= {CNT_W{1'b0}};
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_load && !w_cfg_valid;
            r_detect  <= w_match;

            case (r_state)
                ST_IDLE:  r_state <= (cfg_load && w_cfg_valid) ? ST_ARMED : ST_IDLE;
                ST_ARMED: r_state <= ST_ARMED;
                default:  r_state <= ST_IDLE;
            endcase

            if (cfg_load && w_cfg_valid) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_hist    <= {MAX_LEN{1'b0}};
                r_fill    <= {LEN_W{1'b0}};
            end else if (w_shift) begin
                r_hist    <= w_hist_next;
                r_fill    <= w_fill_next;
            end else begin
                r_hist    <= r_hist;
                r_fill    <= r_fill;
            end

            if (cnt_clear) begin
                r_count <= {CNT_W{1'b0}};
            end else if (w_match && (r_count != w_cnt_max)) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign detect_out   = r_detect;
    assign detect_count = r_count;
    assign cfg_err      = r_cfg_err;
    assign armed        = (r_state == ST_ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: expected detect pulses go through a
// queue scoreboard; counters, armed and cfg_err are checked against constants.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic               seq_in;
    logic               enable;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clear;

    logic               detect_out, detect_out2;
    logic [7:0]         detect_count;
    logic [1:0]         detect_count2;
    logic               cfg_err, cfg_err2;
    logic               armed, armed2;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_q[$];

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .seq_in(seq_in),
        .enable(enable), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
        .detect_out(detect_out), .detect_count(detect_count),
        .cfg_err(cfg_err), .armed(armed)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .seq_in(seq_in),
        .enable(enable), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
        .detect_out(detect_out2), .detect_count(detect_count2),
        .cfg_err(cfg_err2), .armed(armed2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given input bit; detect expectation goes through the queue.
    task automatic step(input logic v, input logic b, input logic exp_det);
        logic e;
        in_valid = v;
        seq_in   = b;
        exp_q.push_back(exp_det);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        chk("detect_out", {31'd0, detect_out}, {31'd0, e});
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic exp_err);
        logic e;
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        exp_q.push_back(1'b0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        chk("load_detect", {31'd0, detect_out}, {31'd0, e});
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; seq_in = 1'b0; enable = 1'b1;
        cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
        cnt_clear = 1'b0;
        #1;
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_count", {24'd0, detect_count}, 32'd0);
        chk("rst_detect", {31'd0, detect_out}, 32'd0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // Bits arriving while IDLE are ignored.
        step(1'b1, 1'b1, 1'b0);
        chk("idle_armed", {31'd0, armed}, 32'd0);

        // 1011 overlapping
        load(8'b1011, 4'd4, 1'b1, 1'b0);
        chk("t1_armed", {31'd0, armed}, 32'd1);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t1_count", {24'd0, detect_count}, 32'd2);

        // 11 overlapping, then non-overlapping after reset
        pulse_reset();
        load(8'b11, 4'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b1);
        chk("t2_ovl_count", {24'd0, detect_count}, 32'd3);
        pulse_reset();
        load(8'b11, 4'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1);
        chk("t2_novl_count", {24'd0, detect_count}, 32'd2);

        // Gaps on in_valid and enable
        load(8'b1011, 4'd4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        enable = 1'b0;
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        enable = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_count", {24'd0, detect_count}, 32'd3);

        // Invalid lengths rejected; previous 1011 config and history kept
        load(8'hFF, 4'd1, 1'b0, 1'b1);
        chk("t4_armed_a", {31'd0, armed}, 32'd1);
        load(8'hFF, 4'd9, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_err_clear", {31'd0, cfg_err}, 32'd0);
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1);
        chk("t4_count_a", {24'd0, detect_count}, 32'd4);

        // Full-length pattern
        load(8'b10110011, 4'd8, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1);
        chk("t4_count_b", {24'd0, detect_count}, 32'd5);

        // cfg_load coincident with final pattern bit discards it
        load(8'b1011, 4'd4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
        in_valid = 1'b1; seq_in = 1'b1;
        load(8'b1011, 4'd4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_count_c", {24'd0, detect_count}, 32'd5);

        // Async reset mid-pattern
        load(8'b1011, 4'd4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5_async_armed", {31'd0, armed}, 32'd0);
        chk("t5_async_count", {24'd0, detect_count}, 32'd0);
        #1;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("t5_armed", {31'd0, armed}, 32'd0);
        chk("t5_count", {24'd0, detect_count}, 32'd0);
        load(8'b1011, 4'd4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t5_count_b", {24'd0, detect_count}, 32'd1);

        // Saturation on the 2-bit counter, then clear beating a coincident match
        pulse_reset();
        load(8'b11, 4'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
        chk("t6_sat", {30'd0, detect_count2}, 32'd3);
        chk("t6_wide", {24'd0, detect_count}, 32'd5);
        cnt_clear = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        cnt_clear = 1'b0;
        chk("t6_detect2", {31'd0, detect_out2}, 32'd1);
        chk("t6_clear2", {30'd0, detect_count2}, 32'd0);
        chk("t6_clear", {24'd0, detect_count}, 32'd0);
        step(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
